// File: rtl/reg_scoreboard.sv
// Purpose: register-write scoreboard; per-register 2-bit pending-writer counters for RAW/overflow hazards.
// Latency: stall is combinational from current inputs; busy_mask and err are registered (one cycle).
// Backpressure: stall holds decode while a source is pending or the destination counter would saturate.
module reg_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic        issue_rs1_used,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_rs2_used,
    input  logic        issue_we,
    input  logic [4:0]  issue_rd,
    input  logic        retire_valid,
    input  logic [4:0]  retire_rd,
    input  logic        flush_valid,
    input  logic [4:0]  flush_rd,
    output logic        stall,
    output logic [31:0] busy_mask,
    output logic        err
);

    logic [1:0]  cnt     [32];
    logic [1:0]  cnt_nxt [32];
    logic [1:0]  dec     [32];
    logic [1:0]  eff     [32];
    logic [31:0] busy_nxt;
    logic        haz_rs1;
    logic        haz_rs2;
    logic        ovf;
    logic        accept;
    logic        uflow;
    logic        inc;
    logic [2:0]  sum;

    // Retiring writes count as already done so a same-cycle reader sees the negedge regfile write.
    always_comb begin
        for (int n = 0; n < 32; n++) begin
            dec[n] = 2'd0;
            eff[n] = 2'd0;
        end
        for (int n = 1; n < 32; n++) begin
            dec[n] = {1'b0, retire_valid && (retire_rd == 5'(n))}
                   + {1'b0, flush_valid && (flush_rd == 5'(n))};
            eff[n] = (cnt[n] > dec[n]) ? (cnt[n] - dec[n]) : 2'd0;
        end
    end

    always_comb begin
        haz_rs1 = issue_rs1_used && (issue_rs1 != 5'd0) && (eff[issue_rs1] != 2'd0);
        haz_rs2 = issue_rs2_used && (issue_rs2 != 5'd0) && (eff[issue_rs2] != 2'd0);
        ovf     = issue_we && (issue_rd != 5'd0) && (eff[issue_rd] == 2'd3);
        stall   = issue_valid && (haz_rs1 || haz_rs2 || ovf);
        accept  = issue_valid && !stall;
    end

    always_comb begin
        uflow    = 1'b0;
        inc      = 1'b0;
        sum      = 3'd0;
        busy_nxt = 32'd0;
        for (int n = 0; n < 32; n++) begin
            cnt_nxt[n] = 2'd0;
        end
        for (int n = 1; n < 32; n++) begin
            inc = accept && issue_we && (issue_rd == 5'(n));
            sum = {1'b0, cnt[n]} + {2'b00, inc};
            // More decrements than pending writers: clamp and flag.
            if (sum < {1'b0, dec[n]}) begin
                uflow      = 1'b1;
                cnt_nxt[n] = 2'd0;
            end else begin
                cnt_nxt[n] = sum[1:0] - dec[n];
            end
            busy_nxt[n] = (cnt_nxt[n] != 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 32; n++) begin
                cnt[n] <= 2'd0;
            end
            busy_mask <= 32'd0;
            err       <= 1'b0;
        end else begin
            for (int n = 0; n < 32; n++) begin
                cnt[n] <= cnt_nxt[n];
            end
            busy_mask <= busy_nxt;
            err       <= err || uflow;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: reference model pushes expected busy/err per cycle, popped after the edge.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic        issue_rs1_used;
    logic [4:0]  issue_rs2;
    logic        issue_rs2_used;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic        flush_valid;
    logic [4:0]  flush_rd;
    logic        stall;
    logic [31:0] busy_mask;
    logic        err;

    reg_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2      (issue_rs2),
        .issue_rs2_used (issue_rs2_used),
        .issue_we       (issue_we),
        .issue_rd       (issue_rd),
        .retire_valid   (retire_valid),
        .retire_rd      (retire_rd),
        .flush_valid    (flush_valid),
        .flush_rd       (flush_rd),
        .stall          (stall),
        .busy_mask      (busy_mask),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] busy;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt [32];
    logic m_err;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clr();
        rst = 1'b0; issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs1_used = 1'b0;
        issue_rs2 = 5'd0; issue_rs2_used = 1'b0; issue_we = 1'b0; issue_rd = 5'd0;
        retire_valid = 1'b0; retire_rd = 5'd0; flush_valid = 1'b0; flush_rd = 5'd0;
    endtask

    task automatic issue_w(input int rd);
        clr(); issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'(rd);
    endtask

    // Model of one clock: expected stall now, expected registered outputs after the edge.
    function automatic logic model_step(output exp_t e);
        int   dec [32];
        int   eff [32];
        logic st;
        for (int n = 0; n < 32; n++) begin
            dec[n] = 0;
            if (n != 0 && retire_valid && retire_rd == 5'(n)) dec[n]++;
            if (n != 0 && flush_valid && flush_rd == 5'(n))   dec[n]++;
            eff[n] = (m_cnt[n] > dec[n]) ? m_cnt[n] - dec[n] : 0;
        end
        st = issue_valid && ((issue_rs1_used && issue_rs1 != 0 && eff[issue_rs1] != 0) ||
                             (issue_rs2_used && issue_rs2 != 0 && eff[issue_rs2] != 0) ||
                             (issue_we && issue_rd != 0 && eff[issue_rd] == 3));
        e.busy = 32'd0;
        for (int n = 1; n < 32; n++) begin
            int s;
            s = m_cnt[n] + ((issue_valid && !st && issue_we && issue_rd == 5'(n)) ? 1 : 0);
            if (rst) m_cnt[n] = 0;
            else if (s < dec[n]) begin m_cnt[n] = 0; m_err = 1'b1; end
            else m_cnt[n] = s - dec[n];
            if (m_cnt[n] != 0) e.busy[n] = 1'b1;
        end
        if (rst) m_err = 1'b0;
        e.err = m_err;
        return st;
    endfunction

    // One cycle with inputs already driven; want_stall < 0 means only the model decides.
    task automatic cycle(input string tag, input int want_stall);
        exp_t e;
        exp_t p;
        logic st;
        #1;
        st = model_step(e);
        chk({tag, ":stall"}, {31'd0, stall}, {31'd0, st});
        if (want_stall >= 0) chk({tag, ":stall_directed"}, {31'd0, stall}, 32'(want_stall));
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        p = exp_q.pop_front();
        chk({tag, ":busy"}, busy_mask, p.busy);
        chk({tag, ":err"}, {31'd0, err}, {31'd0, p.err});
        @(negedge clk);
        clr();
    endtask

    initial begin
        for (int n = 0; n < 32; n++) m_cnt[n] = 0;
        m_err = 1'b0;
        clr();
        @(negedge clk);
        rst = 1'b1;
        cycle("reset", 0);
        chk("reset_busy", busy_mask, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);

        // RAW hazard cleared by same-cycle retire
        issue_w(5);                                              cycle("raw_issue", 0);
        issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1;      cycle("raw_stall", 1);
        issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1;
        retire_valid = 1; retire_rd = 5;                         cycle("raw_bypass", 0);
        chk("raw_busy5", {31'd0, busy_mask[5]}, 32'd0);

        // Saturation at three pending writers
        for (int i = 0; i < 3; i++) begin issue_w(7); cycle("ovf_fill", 0); end
        issue_w(7);                                              cycle("ovf_stall", 1);
        issue_w(7); retire_valid = 1; retire_rd = 7;             cycle("ovf_retire", 0);
        for (int i = 0; i < 2; i++) begin
            retire_valid = 1; retire_rd = 7;                     cycle("ovf_drain", 0);
            chk("ovf_still_busy", {31'd0, busy_mask[7]}, 32'd1);
        end
        retire_valid = 1; retire_rd = 7;                         cycle("ovf_last", 0);
        chk("ovf_empty", {31'd0, busy_mask[7]}, 32'd0);

        // Retire and flush of the same rd
        issue_w(9); cycle("dbl_a", 0);
        issue_w(9); cycle("dbl_b", 0);
        retire_valid = 1; retire_rd = 9; flush_valid = 1; flush_rd = 9; cycle("dbl_dec", -1);
        chk("dbl_busy9", {31'd0, busy_mask[9]}, 32'd0);
        chk("dbl_err", {31'd0, err}, 32'd0);

        // rd 0 retire/flush is ignored
        retire_valid = 1; retire_rd = 0; flush_valid = 1; flush_rd = 0; cycle("r0_ignore", -1);
        chk("r0_err", {31'd0, err}, 32'd0);

        // Underflow is sticky until reset
        retire_valid = 1; retire_rd = 12;                        cycle("uflow", -1);
        chk("uflow_err", {31'd0, err}, 32'd1);
        for (int i = 0; i < 10; i++) cycle("uflow_idle", -1);
        chk("uflow_hold", {31'd0, err}, 32'd1);
        rst = 1;                                                 cycle("uflow_rst", -1);
        chk("uflow_clear", {31'd0, err}, 32'd0);

        // Register 0 never tracked
        for (int i = 0; i < 5; i++) begin
            issue_w(0); issue_rs1_used = 1; issue_rs2_used = 1;  cycle("x0", 0);
            chk("x0_busy", busy_mask, 32'd0);
        end

        // Mid-operation reset with stall still combinational
        issue_w(2); cycle("rst_a", 0);
        issue_w(5); cycle("rst_b", 0);
        chk("rst_mask", busy_mask, 32'h0000_0024);
        issue_w(3); issue_rs1 = 2; issue_rs1_used = 1; rst = 1; cycle("rst_mid", 1);
        chk("rst_mid_busy", busy_mask, 32'd0);
        issue_valid = 1; issue_rs1 = 2; issue_rs1_used = 1;
        issue_rs2 = 5; issue_rs2_used = 1;                       cycle("rst_stale", 0);

        // Random traffic over a few registers
        for (int i = 0; i < 400; i++) begin
            issue_valid    = 1'($urandom_range(0, 1));
            issue_rs1      = 5'($urandom_range(0, 4));
            issue_rs1_used = 1'($urandom_range(0, 1));
            issue_rs2      = 5'($urandom_range(0, 4));
            issue_rs2_used = 1'($urandom_range(0, 1));
            issue_we       = 1'($urandom_range(0, 1));
            issue_rd       = 5'($urandom_range(0, 4));
            retire_rd      = 5'($urandom_range(0, 4));
            retire_valid   = (m_cnt[retire_rd] != 0) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 15) == 0);
            flush_rd       = 5'($urandom_range(0, 4));
            flush_valid    = 1'($urandom_range(0, 7) == 0);
            rst            = 1'($urandom_range(0, 63) == 0);
            cycle("rand", -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
